axis_downsizer_pkt: RTL and testbench

- Parametrised successor to the single-beat AXI4-Stream downsizer.
- Splits each S-wide input beat into 1..RATIO M-wide output words:
  - run-time word count;
  - selectable word order;
  - TLAST propagation, so packet boundaries survive the width conversion.
- Sits between wide DSP/DMA streams (e.g. 128-bit ADC/FIFO outputs) and narrow consumers (32-bit DAC/FIFO/AXI-stream sinks).
- Sustains one output word per clock with no bubbles between input beats.

---
 rtl/axis_downsizer_pkt_if.sv | 26 ++
 rtl/axis_downsizer_pkt.sv | 166 ++++++++++++++++
 tb/tb_axis_downsizer_pkt.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_downsizer_pkt_if.sv
// AXI4-Stream handshake bundle (tdata/tvalid/tlast/tready) shared by both
// sides of the packet-aware downsizer.  The width is set per instance.
interface axis_downsizer_pkt_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  // Source side: drives the payload and valid/last, observes ready.
  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  // Sink side: observes the payload and valid/last, drives ready.
  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_downsizer_pkt.sv
// Packet-aware AXI4-Stream downsizer.  Each wide input beat is held in a
// register and emitted as 1..RATIO narrow words, LSB word first or MSB word
// first, with TLAST marking the final word of a beat that carried TLAST.
// A new beat is accepted in the same cycle as the last word of the current
// one leaves, so a continuously valid input produces gap-free output.
// Optional build macro AXIS_DOWNSIZER_PKT_STATUS_EN adds sts_data with
// packet/beat counters.
module axis_downsizer_pkt #(
  parameter int S_AXIS_TDATA_WIDTH = 128,
  parameter int M_AXIS_TDATA_WIDTH = 32,
  parameter bit MSB_FIRST          = 1'b0
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [15:0]                 cfg_data,
  axis_downsizer_pkt_if.slave         s_axis,
  axis_downsizer_pkt_if.master        m_axis
`ifdef AXIS_DOWNSIZER_PKT_STATUS_EN
  ,
  output logic [31:0]                 sts_data
`endif
);

  localparam int RATIO      = S_AXIS_TDATA_WIDTH / M_AXIS_TDATA_WIDTH;
  localparam int CNTR_WIDTH = (RATIO > 2) ? $clog2(RATIO) : 1;
  localparam logic [CNTR_WIDTH-1:0] N_MAX = CNTR_WIDTH'(RATIO - 1);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t                          state_q, state_d;
  logic [S_AXIS_TDATA_WIDTH-1:0]   beat_q, beat_d;
  logic [CNTR_WIDTH-1:0]           idx_q, idx_d;
  logic [CNTR_WIDTH-1:0]           n_q, n_d;
  logic                            last_q, last_d;

  logic                            busy;
  logic                            at_end;
  logic                            s_acc;
  logic                            m_hs;
  logic                            m_last;
  logic [CNTR_WIDTH-1:0]           cfg_n;
  logic [CNTR_WIDTH-1:0]           sel;
  logic [M_AXIS_TDATA_WIDTH-1:0]   words [RATIO];

  // Slice the held beat into its narrow words.
  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_words
      assign words[gi] = beat_q[gi*M_AXIS_TDATA_WIDTH +: M_AXIS_TDATA_WIDTH];
    end
  endgenerate

  // Word count from cfg_data; clip only when the counter can exceed RATIO-1.
  generate
    if ((1 << CNTR_WIDTH) > RATIO) begin : g_sat
      assign cfg_n = (cfg_data[CNTR_WIDTH-1:0] > N_MAX) ? N_MAX : cfg_data[CNTR_WIDTH-1:0];
    end else begin : g_nosat
      assign cfg_n = cfg_data[CNTR_WIDTH-1:0];
    end
    if (CNTR_WIDTH < 16) begin : g_cfg_hi
      logic unused_cfg_hi;
      assign unused_cfg_hi = ^cfg_data[15:CNTR_WIDTH];
    end
  endgenerate

  assign busy   = (state_q == EMIT);
  assign at_end = (idx_q == n_q);
  assign m_hs   = busy & m_axis.tready;
  assign m_last = busy & last_q & at_end;

  // Ready when empty, or when the final word of the held beat is leaving now.
  assign s_axis.tready = ~areset & (~busy | (m_axis.tready & at_end));
  assign s_acc         = s_axis.tvalid & s_axis.tready;

  // MSB-first order walks the kept words downward from word n.
  assign sel = MSB_FIRST ? (n_q - idx_q) : idx_q;

  assign m_axis.tvalid = busy;
  assign m_axis.tlast  = m_last;
  assign m_axis.tdata  = words[sel];

  // Next-state logic: load on acceptance, step idx per output handshake.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    idx_d   = idx_q;
    n_d     = n_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (s_acc) begin
          state_d = EMIT;
          beat_d  = s_axis.tdata;
          n_d     = cfg_n;
          last_d  = s_axis.tlast;
          idx_d   = '0;
        end
      end
      EMIT: begin
        if (m_hs) begin
          if (!at_end) begin
            idx_d = idx_q + 1'b1;
          end else if (s_acc) begin
            beat_d = s_axis.tdata;
            n_d    = cfg_n;
            last_d = s_axis.tlast;
            idx_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and beat registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      idx_q   <= '0;
      n_q     <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      last_q  <= last_d;
    end
  end

`ifdef AXIS_DOWNSIZER_PKT_STATUS_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] beat_cnt_q, beat_cnt_d;

  // Count packets leaving and beats entering; both wrap at 16 bits.
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    beat_cnt_d = beat_cnt_q;
    if (m_hs && m_last) begin
      pkt_cnt_d = pkt_cnt_q + 16'd1;
    end
    if (s_acc) begin
      beat_cnt_d = beat_cnt_q + 16'd1;
    end
  end

  // Status counter registers, cleared by reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      pkt_cnt_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign sts_data = {pkt_cnt_q, beat_cnt_q};
`endif

endmodule

// File: tb/tb_axis_downsizer_pkt.sv
// Self-checking bench for axis_downsizer_pkt.  Two instances (LSB-first and
// MSB-first) receive identical stimulus; directed scenarios use constant
// expectations and a randomized run is scored against a word queue built
// from the splitting rules.
module tb_axis_downsizer_pkt;
  localparam int S     = 128;
  localparam int M     = 32;
  localparam int RATIO = S / M;
  localparam int CW    = (RATIO > 2) ? $clog2(RATIO) : 1;

  logic          clk = 1'b0;
  logic          areset = 1'b1;
  logic [15:0]   cfg_data = 16'd0;
  logic [S-1:0]  s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          m_tready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axis_downsizer_pkt_if #(.DATA_WIDTH(S)) s0_if ();
  axis_downsizer_pkt_if #(.DATA_WIDTH(S)) s1_if ();
  axis_downsizer_pkt_if #(.DATA_WIDTH(M)) m0_if ();
  axis_downsizer_pkt_if #(.DATA_WIDTH(M)) m1_if ();

  assign s0_if.tdata  = s_tdata;
  assign s0_if.tvalid = s_tvalid;
  assign s0_if.tlast  = s_tlast;
  assign s1_if.tdata  = s_tdata;
  assign s1_if.tvalid = s_tvalid;
  assign s1_if.tlast  = s_tlast;
  assign m0_if.tready = m_tready;
  assign m1_if.tready = m_tready;

`ifdef AXIS_DOWNSIZER_PKT_STATUS_EN
  logic [31:0] sts0;
  logic [31:0] sts1;
`endif

  axis_downsizer_pkt #(
    .S_AXIS_TDATA_WIDTH(S),
    .M_AXIS_TDATA_WIDTH(M),
    .MSB_FIRST(1'b0)
  ) dut0 (
    .aclk(clk),
    .areset(areset),
    .cfg_data(cfg_data),
    .s_axis(s0_if),
    .m_axis(m0_if)
`ifdef AXIS_DOWNSIZER_PKT_STATUS_EN
    ,
    .sts_data(sts0)
`endif
  );

  axis_downsizer_pkt #(
    .S_AXIS_TDATA_WIDTH(S),
    .M_AXIS_TDATA_WIDTH(M),
    .MSB_FIRST(1'b1)
  ) dut1 (
    .aclk(clk),
    .areset(areset),
    .cfg_data(cfg_data),
    .s_axis(s1_if),
    .m_axis(m1_if)
`ifdef AXIS_DOWNSIZER_PKT_STATUS_EN
    ,
    .sts_data(sts1)
`endif
  );

  localparam logic [S-1:0] BEAT_A = 128'h44444444_33333333_22222222_11111111;
  localparam logic [S-1:0] BEAT_B = 128'h88888888_77777777_66666666_55555555;

  function automatic logic [M-1:0] word_of(input logic [S-1:0] b, input int j);
    return b[j*M +: M];
  endfunction

  function automatic int words_minus_one(input logic [15:0] cfg);
    int bits;
    bits = int'(cfg) % (1 << CW);
    return (bits > RATIO - 1) ? RATIO - 1 : bits;
  endfunction

  function automatic logic [S-1:0] rand_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    areset   = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = rand_beat();
    cfg_data = 16'd3;
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (m0_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid0: got %b expected 0", m0_if.tvalid); end
    n_checks++; if (m0_if.tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast0: got %b expected 0", m0_if.tlast); end
    n_checks++; if (m0_if.tdata !== 32'h0) begin n_fail++; $display("FAIL reset_tdata0: got %h expected 0", m0_if.tdata); end
    n_checks++; if (s0_if.tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready0: got %b expected 0", s0_if.tready); end
    n_checks++; if (m1_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid1: got %b expected 0", m1_if.tvalid); end
    n_checks++; if (s1_if.tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready1: got %b expected 0", s1_if.tready); end
    next_cycle();
    areset   = 1'b0;
    s_tvalid = 1'b0;
    @(negedge clk);
    n_checks++; if (s0_if.tready !== 1'b1) begin n_fail++; $display("FAIL release_tready0: got %b expected 1", s0_if.tready); end
    n_checks++; if (m0_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL release_tvalid0: got %b expected 0", m0_if.tvalid); end
    $display("reset: outputs cleared, ready after release");
    next_cycle();
  endtask

  task automatic test_order();
    cfg_data = 16'd3;
    m_tready = 1'b1;
    s_tdata  = BEAT_A;
    s_tlast  = 1'b0;
    s_tvalid = 1'b1;
    @(negedge clk);
    n_checks++; if (s0_if.tready !== 1'b1) begin n_fail++; $display("FAIL order_accept: got %b expected 1", s0_if.tready); end
    next_cycle();
    s_tvalid = 1'b0;
    s_tdata  = rand_beat();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++; if (m0_if.tvalid !== 1'b1) begin n_fail++; $display("FAIL order_valid[%0d]: got %b expected 1", k, m0_if.tvalid); end
      n_checks++; if (m0_if.tdata !== word_of(BEAT_A, k)) begin n_fail++; $display("FAIL order_lsb[%0d]: got %h expected %h", k, m0_if.tdata, word_of(BEAT_A, k)); end
      n_checks++; if (m1_if.tdata !== word_of(BEAT_A, 3 - k)) begin n_fail++; $display("FAIL order_msb[%0d]: got %h expected %h", k, m1_if.tdata, word_of(BEAT_A, 3 - k)); end
      n_checks++; if (s0_if.tready !== (k == 3)) begin n_fail++; $display("FAIL order_tready[%0d]: got %b expected %b", k, s0_if.tready, (k == 3)); end
      n_checks++; if (m0_if.tlast !== 1'b0) begin n_fail++; $display("FAIL order_tlast[%0d]: got %b expected 0", k, m0_if.tlast); end
      next_cycle();
    end
    @(negedge clk);
    n_checks++; if (m0_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL order_idle: got %b expected 0", m0_if.tvalid); end
    $display("order: beat %h emitted as 4 words", BEAT_A);
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [M-1:0] e0, e1;
    cfg_data = 16'd3;
    m_tready = 1'b1;
    s_tlast  = 1'b0;
    s_tdata  = BEAT_A;
    s_tvalid = 1'b1;
    next_cycle();
    s_tdata = BEAT_B;
    for (int i = 0; i < 8; i++) begin
      e0 = (i < 4) ? word_of(BEAT_A, i) : word_of(BEAT_B, i - 4);
      e1 = (i < 4) ? word_of(BEAT_A, 3 - i) : word_of(BEAT_B, 7 - i);
      @(negedge clk);
      n_checks++; if (m0_if.tvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, m0_if.tvalid); end
      n_checks++; if (m0_if.tdata !== e0) begin n_fail++; $display("FAIL b2b_lsb[%0d]: got %h expected %h", i, m0_if.tdata, e0); end
      n_checks++; if (m1_if.tdata !== e1) begin n_fail++; $display("FAIL b2b_msb[%0d]: got %h expected %h", i, m1_if.tdata, e1); end
      n_checks++; if (s0_if.tready !== ((i % 4) == 3)) begin n_fail++; $display("FAIL b2b_tready[%0d]: got %b expected %b", i, s0_if.tready, ((i % 4) == 3)); end
      next_cycle();
      if (i == 3) s_tvalid = 1'b0;
    end
    @(negedge clk);
    n_checks++; if (m0_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b expected 0", m0_if.tvalid); end
    $display("back_to_back: two beats, 8 contiguous words");
    next_cycle();
  endtask

  task automatic test_msb_tlast();
    cfg_data = 16'd1;
    m_tready = 1'b1;
    s_tdata  = BEAT_A;
    s_tlast  = 1'b1;
    s_tvalid = 1'b1;
    next_cycle();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++; if (m1_if.tdata !== word_of(BEAT_A, 1 - k)) begin n_fail++; $display("FAIL msb_data[%0d]: got %h expected %h", k, m1_if.tdata, word_of(BEAT_A, 1 - k)); end
      n_checks++; if (m0_if.tdata !== word_of(BEAT_A, k)) begin n_fail++; $display("FAIL lsb2_data[%0d]: got %h expected %h", k, m0_if.tdata, word_of(BEAT_A, k)); end
      n_checks++; if (m1_if.tlast !== (k == 1)) begin n_fail++; $display("FAIL msb_tlast[%0d]: got %b expected %b", k, m1_if.tlast, (k == 1)); end
      n_checks++; if (m0_if.tlast !== (k == 1)) begin n_fail++; $display("FAIL lsb2_tlast[%0d]: got %b expected %b", k, m0_if.tlast, (k == 1)); end
      next_cycle();
    end
    @(negedge clk);
    n_checks++; if (m1_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL msb_idle: got %b expected 0", m1_if.tvalid); end
    n_checks++; if (m1_if.tlast !== 1'b0) begin n_fail++; $display("FAIL msb_idle_tlast: got %b expected 0", m1_if.tlast); end
    $display("msb_tlast: 2 words, tlast on second");
    next_cycle();
  endtask

  task automatic test_saturation_backpressure();
    logic [S-1:0] r;
    int pat [6] = '{1, 0, 0, 1, 1, 1};
    int idx;
    r        = rand_beat();
    cfg_data = 16'd7;
    m_tready = 1'b1;
    s_tdata  = r;
    s_tlast  = 1'b1;
    s_tvalid = 1'b1;
    next_cycle();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      m_tready = (pat[c] != 0);
      @(negedge clk);
      n_checks++; if (m0_if.tvalid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b expected 1", c, m0_if.tvalid); end
      n_checks++; if (m0_if.tdata !== word_of(r, idx)) begin n_fail++; $display("FAIL bp_lsb[%0d]: got %h expected %h", c, m0_if.tdata, word_of(r, idx)); end
      n_checks++; if (m1_if.tdata !== word_of(r, 3 - idx)) begin n_fail++; $display("FAIL bp_msb[%0d]: got %h expected %h", c, m1_if.tdata, word_of(r, 3 - idx)); end
      n_checks++; if (m0_if.tlast !== (idx == 3)) begin n_fail++; $display("FAIL bp_tlast[%0d]: got %b expected %b", c, m0_if.tlast, (idx == 3)); end
      n_checks++; if (s0_if.tready !== (pat[c] != 0 && idx == 3)) begin n_fail++; $display("FAIL bp_tready[%0d]: got %b expected %b", c, s0_if.tready, (pat[c] != 0 && idx == 3)); end
      if (pat[c] != 0) idx++;
      next_cycle();
    end
    m_tready = 1'b1;
    @(negedge clk);
    n_checks++; if (m0_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got %b expected 0", m0_if.tvalid); end
    $display("saturation_backpressure: cfg 7 -> 4 words through stalls");
    next_cycle();
  endtask

  task automatic test_reset_mid();
    logic [S-1:0] r, c2;
    r        = rand_beat();
    c2       = rand_beat();
    cfg_data = 16'd3;
    m_tready = 1'b1;
    s_tdata  = r;
    s_tlast  = 1'b0;
    s_tvalid = 1'b1;
    next_cycle();
    s_tvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++; if (m0_if.tdata !== word_of(r, k)) begin n_fail++; $display("FAIL rstmid_word[%0d]: got %h expected %h", k, m0_if.tdata, word_of(r, k)); end
      next_cycle();
    end
    areset = 1'b1;
    @(negedge clk);
    n_checks++; if (s0_if.tready !== 1'b0) begin n_fail++; $display("FAIL rstmid_tready_comb: got %b expected 0", s0_if.tready); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (m0_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_tvalid0: got %b expected 0", m0_if.tvalid); end
    n_checks++; if (m1_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_tvalid1: got %b expected 0", m1_if.tvalid); end
    n_checks++; if (m0_if.tdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_tdata0: got %h expected 0", m0_if.tdata); end
    n_checks++; if (s0_if.tready !== 1'b0) begin n_fail++; $display("FAIL rstmid_tready: got %b expected 0", s0_if.tready); end
    next_cycle();
    areset   = 1'b0;
    s_tdata  = c2;
    s_tvalid = 1'b1;
    @(negedge clk);
    n_checks++; if (s1_if.tready !== 1'b1) begin n_fail++; $display("FAIL rstmid_reaccept: got %b expected 1", s1_if.tready); end
    next_cycle();
    s_tvalid = 1'b0;
    @(negedge clk);
    n_checks++; if (m0_if.tdata !== word_of(c2, 0)) begin n_fail++; $display("FAIL rstmid_new_lsb: got %h expected %h", m0_if.tdata, word_of(c2, 0)); end
    n_checks++; if (m1_if.tdata !== word_of(c2, 3)) begin n_fail++; $display("FAIL rstmid_new_msb: got %h expected %h", m1_if.tdata, word_of(c2, 3)); end
    $display("reset_mid: beat dropped, new beat restarts at word 0");
    repeat (4) next_cycle();
  endtask

  task automatic test_random();
    logic [M:0] q0 [$];
    logic [M:0] q1 [$];
    logic       exp_valid, exp_rdy;
    int         n;
    areset = 1'b1;
    s_tvalid = 1'b0;
    next_cycle();
    areset = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      s_tvalid = ($urandom_range(0, 3) != 0);
      s_tdata  = rand_beat();
      s_tlast  = $urandom_range(0, 1) == 1;
      cfg_data = 16'($urandom_range(0, 15)) | (16'($urandom_range(0, 1)) << 12);
      m_tready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      exp_valid = (q0.size() > 0);
      exp_rdy   = (q0.size() == 0) || (m_tready && q0.size() == 1);
      n_checks++; if (m0_if.tvalid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid0 @%0d: got %b expected %b", cyc, m0_if.tvalid, exp_valid); end
      n_checks++; if (m1_if.tvalid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid1 @%0d: got %b expected %b", cyc, m1_if.tvalid, exp_valid); end
      n_checks++; if (s0_if.tready !== exp_rdy) begin n_fail++; $display("FAIL rnd_tready0 @%0d: got %b expected %b", cyc, s0_if.tready, exp_rdy); end
      n_checks++; if (s1_if.tready !== exp_rdy) begin n_fail++; $display("FAIL rnd_tready1 @%0d: got %b expected %b", cyc, s1_if.tready, exp_rdy); end
      if (exp_valid) begin
        n_checks++; if ({m0_if.tlast, m0_if.tdata} !== q0[0]) begin n_fail++; $display("FAIL rnd_word0 @%0d: got %b/%h expected %b/%h", cyc, m0_if.tlast, m0_if.tdata, q0[0][M], q0[0][M-1:0]); end
        n_checks++; if ({m1_if.tlast, m1_if.tdata} !== q1[0]) begin n_fail++; $display("FAIL rnd_word1 @%0d: got %b/%h expected %b/%h", cyc, m1_if.tlast, m1_if.tdata, q1[0][M], q1[0][M-1:0]); end
        if (m_tready) begin
          void'(q0.pop_front());
          void'(q1.pop_front());
        end
      end
      if (s_tvalid && exp_rdy) begin
        n = words_minus_one(cfg_data);
        for (int j = 0; j <= n; j++) begin
          q0.push_back({s_tlast && (j == n), word_of(s_tdata, j)});
          q1.push_back({s_tlast && (j == n), word_of(s_tdata, n - j)});
        end
        $display("random: cycle %0d beat accepted, %0d words, tlast=%0b", cyc, n + 1, s_tlast);
      end
      next_cycle();
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (6) next_cycle();
  endtask

`ifdef AXIS_DOWNSIZER_PKT_STATUS_EN
  task automatic test_status();
    int lastpat [5] = '{1, 0, 0, 1, 0};
    areset   = 1'b1;
    s_tvalid = 1'b0;
    next_cycle();
    areset   = 1'b0;
    cfg_data = 16'd0;
    m_tready = 1'b1;
    for (int b = 0; b < 5; b++) begin
      s_tdata  = rand_beat();
      s_tlast  = (lastpat[b] != 0);
      s_tvalid = 1'b1;
      next_cycle();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk);
    n_checks++; if (sts0 !== 32'h0002_0005) begin n_fail++; $display("FAIL status0: got %h expected 00020005", sts0); end
    n_checks++; if (sts1 !== 32'h0002_0005) begin n_fail++; $display("FAIL status1: got %h expected 00020005", sts1); end
    $display("status: 5 beats, 2 packets");
    next_cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_order();
    test_back_to_back();
    test_msb_tlast();
    test_saturation_backpressure();
    test_reset_mid();
    test_random();
`ifdef AXIS_DOWNSIZER_PKT_STATUS_EN
    test_status();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
